pcpi_serial_bridge: RTL and testbench
=====================================

# pcpi_serial_bridge

Parametrised successor to the nibble-loader front end of the TinyTapeout PCPI coprocessor wrapper. It assembles an `INSN_W`-bit instruction from `SEG_W`-bit segments under a valid/ready handshake and issues it on a full PCPI master interface: valid is held until ready or timeout. On a write-back result it returns `pcpi_rd` as segments over a second handshake. It sits between the chip pins and a PCPI coprocessor (e.g. the fused matrix-multiply unit).

## Interface
- `SEG_W`, 4, segment width in bits; must divide `INSN_W` and `RD_W`.
- `INSN_W`, 32, instruction width; `NSEG_IN = INSN_W/SEG_W`.
- `RD_W`, 32, result width; `NSEG_OUT = RD_W/SEG_W`.
- `TIMEOUT`, 16, issue cycles allowed without `pcpi_wait` before abort; 0 disables the timeout.
- `clk  in  1  clock`, the only clock.
- `rst_n  in  1  reset`, asynchronous, active-low.
- `in_valid  in  1  segment present`
- `in_data  in  SEG_W  segment, LSB-first order`
- `in_ready  out  1  bridge accepts a segment this cycle`
- `pcpi_valid  out  1  instruction offered`
- `pcpi_insn  out  INSN_W  registered instruction`
- `pcpi_ready  in  1  coprocessor done`
- `pcpi_wr  in  1  result valid, qualified by pcpi_ready`
- `pcpi_wait  in  1  coprocessor claims instruction`
- `pcpi_rd  in  RD_W  result`
- `out_valid  out  1  result segment present`
- `out_data  out  SEG_W  result segment, LSB-first`
- `out_ready  in  1  consumer takes segment`
- `busy  out  1  transaction in progress`
- `err_timeout  out  1  sticky: last issue timed out`

## Operation
- The FSM has three states: RECV, ISSUE, SEND. The reset state is RECV.
- RECV:
  - `in_ready=1`.
  - Each `in_valid&&in_ready` writes `in_data` into `pcpi_insn[k*SEG_W +: SEG_W]`, where k is the segment counter, then increments k.
  - Accepting the segment with k=0 clears `err_timeout`.
  - Accepting the segment with k=NSEG_IN-1 resets k to 0, goes to ISSUE and sets `pcpi_valid`.
- ISSUE:
  - `pcpi_valid=1` and `pcpi_insn` are held stable.
  - The timeout counter increments each cycle in which `pcpi_wait=0`.
  - The timeout counter clears to 0 on any cycle in which `pcpi_wait=1`.
- ISSUE, on `pcpi_ready`:
  - Clear `pcpi_valid`.
  - If `pcpi_wr=1`, capture `pcpi_rd` into the output shift register and go to SEND.
  - If `pcpi_wr=0`, go to RECV.
- ISSUE, on timeout (counter reaches `TIMEOUT` with `TIMEOUT`≠0): clear `pcpi_valid`, set `err_timeout`, go to RECV.
- SEND:
  - `out_valid=1` and `out_data` = the low segment of the shift register.
  - On `out_ready`, shift right by `SEG_W` and increment the output count.
  - After NSEG_OUT handshakes, go to RECV.
- `in_ready` is combinational: `state==RECV`.
- `busy` = `state!=RECV || k!=0`.
- All other outputs are registered.

## Timing
- Reset, asynchronous, on `rst_n` low. All of the following take effect immediately and hold while low:
  - `pcpi_valid=0`, `pcpi_insn=0`, `out_valid=0`, `out_data=0`, `busy=0`, `err_timeout=0`.
  - k, the output count and the timeout counter are all 0.
  - `in_ready=1` (the state is RECV).
  - A reset mid-receive or mid-send discards the partial word.
- `pcpi_valid` rises on the clock edge that accepts the last input segment, i.e. it is visible the cycle after that handshake.
- `pcpi_valid` falls on the edge after the cycle in which `pcpi_ready` or the timeout is seen.
- The coprocessor must not see valid high in the cycle after asserting ready.
- `pcpi_ready` and the timeout in the same cycle: ready wins and `err_timeout` is not set.
- `pcpi_ready` outside ISSUE is ignored.
- `out_valid` rises the cycle after `pcpi_ready&&pcpi_wr`.
- After the last `out_ready`, `out_valid` falls and `in_ready` rises on the same edge.
- Minimum transaction length: NSEG_IN + 1 + latency + NSEG_OUT cycles.
- `out_ready` held low stalls SEND indefinitely; there is no timeout in SEND.
- `in_valid` outside RECV is not consumed; the source must hold it.

## Structure
- Package `pcpi_bridge_pkg`:
  - State enum (RECV, ISSUE, SEND).
  - `clog2`-based counter-width helpers.
  - Elaboration check that `SEG_W` divides `INSN_W` and `RD_W`.
- Sub-module `pcpi_seg_serializer`, parametrised on `SEG_W` and `RD_W`: loadable shift register plus count, valid/ready output, `done` pulse.
- The top level contains the FSM, the input assembler and the timeout counter.

## Test plan
All scenarios use default parameters.
- Input assembly: send 3,3,0,0,0,0,2,0 back-to-back → `pcpi_insn=0x02000033`; `pcpi_valid` high the cycle after the 8th accept; `busy` high from the 1st accept.
- Write-back: hold ready 3 cycles after valid, with `pcpi_wr=1`, `pcpi_rd=0xDEADBEEF` → `pcpi_valid` drops the next cycle; output segments F,E,E,B,D,A,E,D; `in_ready` high after the 8th `out_ready`.
- Output backpressure: `out_ready` toggling every 3 cycles → sequence unchanged and no segment duplicated or lost. With `pcpi_wr=0` on ready → no `out_valid`; the state returns to RECV.
- Timeout: `pcpi_wait=0` and no ready → `pcpi_valid` low after 16 cycles; `err_timeout=1`, cleared by the next first-segment accept. With `pcpi_wait=1` held for 100 cycles → no timeout.
- Ready and timeout coincident: `pcpi_ready` asserted in the 16th cycle → completes normally with `err_timeout=0`.
- Reset mid-operation: assert `rst_n=0` after 5 segments, and again during SEND → all outputs go to reset values asynchronously; a fresh 8-segment load then yields the correct instruction.

Source files
------------

// File: rtl/pcpi_bridge_pkg.sv
// Shared types and elaboration helpers for the PCPI serial bridge.
package pcpi_bridge_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    ISSUE = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit seg_w_ok(input int seg_w, input int insn_w, input int rd_w);
    return (seg_w > 0) && ((insn_w % seg_w) == 0) && ((rd_w % seg_w) == 0);
  endfunction

endpackage

// File: rtl/pcpi_seg_serializer.sv
// Loadable right-shift register that emits a word as LSB-first segments
// over a valid/ready handshake; done pulses with the final handshake.
module pcpi_seg_serializer
  import pcpi_bridge_pkg::*;
#(
  parameter int SEG_W = 4,
  parameter int RD_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [RD_W-1:0]  load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SEG_W-1:0] out_data,
  output logic             done
);

  localparam int NSEG  = RD_W / SEG_W;
  localparam int CNT_W = cnt_w(NSEG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSEG - 1);

  logic [RD_W-1:0]  shreg;
  logic [CNT_W-1:0] cnt;
  logic             valid;
  logic             take;

  assign take      = valid && out_ready;
  assign done      = take && (cnt == LAST);
  assign out_valid = valid;
  assign out_data  = shreg[SEG_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (take) begin
      // zero fill leaves the register clear once the word has drained
      shreg <= shreg >> SEG_W;
      if (done) begin
        cnt   <= '0;
        valid <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pcpi_serial_bridge.sv
// Segment-serial front end for a PCPI coprocessor: assembles an instruction,
// issues it with a stall timeout, and streams a write-back result out.
//
// state | meaning
// RECV  | accepting instruction segments
// ISSUE | pcpi_valid held, waiting for pcpi_ready or timeout
// SEND  | streaming the captured pcpi_rd out as segments
module pcpi_serial_bridge
  import pcpi_bridge_pkg::*;
#(
  parameter int SEG_W   = 4,
  parameter int INSN_W  = 32,
  parameter int RD_W    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [SEG_W-1:0]  in_data,
  output logic              in_ready,
  output logic              pcpi_valid,
  output logic [INSN_W-1:0] pcpi_insn,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic              pcpi_wait,
  input  logic [RD_W-1:0]   pcpi_rd,
  output logic              out_valid,
  output logic [SEG_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_timeout
);

  localparam int NSEG_IN = INSN_W / SEG_W;
  localparam int K_W     = cnt_w(NSEG_IN);
  localparam int TMO_W   = cnt_w(TIMEOUT + 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(NSEG_IN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  if (!seg_w_ok(SEG_W, INSN_W, RD_W)) begin : g_bad_seg_w
    $error("pcpi_serial_bridge: SEG_W must divide INSN_W and RD_W");
  end

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q;
  logic [INSN_W-1:0]   insn_q;
  logic                pcpi_valid_q;
  logic                err_q;
  logic [TMO_W-1:0]    tmo_q;

  logic accept;
  logic last_seg;
  logic tmo_hit;
  logic issue_end;
  logic set_err;
  logic ser_load;
  logic ser_done;

  always_comb begin
    state_d   = state_q;
    issue_end = 1'b0;
    set_err   = 1'b0;
    ser_load  = 1'b0;
    accept    = (state_q == RECV) && in_valid;
    last_seg  = accept && (k_q == K_LAST);
    // the cycle whose stall would bring the count to TIMEOUT is the timeout cycle
    tmo_hit   = (TIMEOUT != 0) && !pcpi_wait && (tmo_q == TMO_LAST);
    case (state_q)
      RECV: begin
        if (last_seg) state_d = ISSUE;
      end
      ISSUE: begin
        if (pcpi_ready) begin
          issue_end = 1'b1;
          if (pcpi_wr) begin
            ser_load = 1'b1;
            state_d  = SEND;
          end else begin
            state_d = RECV;
          end
        end else if (tmo_hit) begin
          issue_end = 1'b1;
          set_err   = 1'b1;
          state_d   = RECV;
        end
      end
      SEND: begin
        if (ser_done) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RECV;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q          <= '0;
      insn_q       <= '0;
      pcpi_valid_q <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NSEG_IN; i++) begin
          if (k_q == K_W'(i)) insn_q[i*SEG_W +: SEG_W] <= in_data;
        end
        k_q <= last_seg ? '0 : k_q + K_W'(1);
        if (k_q == '0) err_q <= 1'b0;
      end
      if (last_seg)  pcpi_valid_q <= 1'b1;
      if (issue_end) pcpi_valid_q <= 1'b0;
      if (set_err)   err_q        <= 1'b1;
      if ((state_q == ISSUE) && !issue_end) tmo_q <= pcpi_wait ? '0 : tmo_q + TMO_W'(1);
      else                                  tmo_q <= '0;
    end
  end

  pcpi_seg_serializer #(
    .SEG_W (SEG_W),
    .RD_W  (RD_W)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (pcpi_rd),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .done      (ser_done)
  );

  assign in_ready    = (state_q == RECV);
  assign busy        = (state_q != RECV) || (k_q != '0);
  assign pcpi_valid  = pcpi_valid_q;
  assign pcpi_insn   = insn_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// Directed and randomized checks of pcpi_serial_bridge against a
// transaction-level reference (word packing, stall run length, segment order).
module tb_pcpi_serial_bridge;

  localparam int SEG_W    = 4;
  localparam int INSN_W   = 32;
  localparam int RD_W     = 32;
  localparam int TIMEOUT  = 16;
  localparam int NSEG_IN  = INSN_W / SEG_W;
  localparam int NSEG_OUT = RD_W / SEG_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [SEG_W-1:0]  in_data = '0;
  logic              in_ready;
  logic              pcpi_valid;
  logic [INSN_W-1:0] pcpi_insn;
  logic              pcpi_ready = 1'b0;
  logic              pcpi_wr = 1'b0;
  logic              pcpi_wait = 1'b0;
  logic [RD_W-1:0]   pcpi_rd = '0;
  logic              out_valid;
  logic [SEG_W-1:0]  out_data;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pcpi_serial_bridge #(
    .SEG_W   (SEG_W),
    .INSN_W  (INSN_W),
    .RD_W    (RD_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_ready  (pcpi_ready),
    .pcpi_wr     (pcpi_wr),
    .pcpi_wait   (pcpi_wait),
    .pcpi_rd     (pcpi_rd),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [INSN_W-1:0] w);
    for (int i = 0; i < NSEG_IN; i++) begin
      in_valid = 1'b1;
      in_data  = w[i*SEG_W +: SEG_W];
      check("recv_in_ready", in_ready, 1);
      check("recv_valid_low", pcpi_valid, 0);
      step();
      check("recv_busy", busy, 1);
      if (i == 0) check("recv_err_clear", err_timeout, 0);
    end
    in_valid = 1'b0;
    check("issue_valid_rise", pcpi_valid, 1);
    check("issue_insn", pcpi_insn, w);
    check("issue_in_ready_low", in_ready, 0);
  endtask

  // Coprocessor answers with ready in the (delay+1)th issue cycle.
  task automatic issue_ready(input int delay, input logic wr, input logic [RD_W-1:0] rd,
                             input logic [INSN_W-1:0] insn);
    for (int c = 0; c < delay; c++) begin
      check("issue_valid_hold", pcpi_valid, 1);
      check("issue_insn_stable", pcpi_insn, insn);
      check("issue_in_ready", in_ready, 0);
      step();
    end
    pcpi_ready = 1'b1;
    pcpi_wr    = wr;
    pcpi_rd    = rd;
    check("issue_valid_at_ready", pcpi_valid, 1);
    step();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = $urandom();
    check("ready_valid_drop", pcpi_valid, 0);
    check("ready_err_low", err_timeout, 0);
    check("ready_out_valid", out_valid, wr);
    check("ready_in_ready", in_ready, !wr);
  endtask

  // mode 0: always ready, 1: 3 low / 3 high, else: random
  task automatic recv_word(input logic [RD_W-1:0] rd, input int mode);
    int got = 0;
    int cyc = 0;
    logic [SEG_W-1:0] exp_seg;
    while (got < NSEG_OUT && cyc < 500) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc / 3) % 2) == 1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      check("send_out_valid", out_valid, 1);
      check("send_in_ready", in_ready, 0);
      if (out_ready) begin
        exp_seg = rd[got*SEG_W +: SEG_W];
        check("send_segment", out_data, exp_seg);
        got++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("send_count", got, NSEG_OUT);
    check("send_out_valid_fall", out_valid, 0);
    check("send_in_ready_rise", in_ready, 1);
    check("send_busy_low", busy, 0);
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_wait  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_pcpi_valid", pcpi_valid, 0);
    check("rst_pcpi_insn", pcpi_insn, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [INSN_W-1:0] w;
    logic [RD_W-1:0]   rd;
    logic              wr;
    int                delay;
    int                run;
    bit                ended;
    bit                timed_out;

    step();
    do_reset();

    // ready outside ISSUE has no effect
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'h1234_5678;
    step();
    step();
    check("idle_ready_valid", pcpi_valid, 0);
    check("idle_ready_out_valid", out_valid, 0);
    check("idle_ready_in_ready", in_ready, 1);
    check("idle_ready_busy", busy, 0);
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;

    // assembly of 3,3,0,0,0,0,2,0 and the DEADBEEF write-back; in_valid held during ISSUE
    send_word(32'h0200_0033);
    in_valid = 1'b1;
    in_data  = 4'hF;
    issue_ready(3, 1'b1, 32'hDEAD_BEEF, 32'h0200_0033);
    in_valid = 1'b0;
    recv_word(32'hDEAD_BEEF, 0);

    // output backpressure
    w  = $urandom();
    rd = $urandom();
    send_word(w);
    issue_ready(5, 1'b1, rd, w);
    recv_word(rd, 1);

    // ready without write-back
    w = $urandom();
    send_word(w);
    issue_ready(2, 1'b0, 32'hCAFE_F00D, w);
    step();
    step();
    check("nowr_out_valid", out_valid, 0);
    check("nowr_in_ready", in_ready, 1);
    check("nowr_busy", busy, 0);

    // stall timeout: valid is offered for exactly TIMEOUT cycles
    w = $urandom();
    send_word(w);
    pcpi_wait = 1'b0;
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      check("tmo_valid_hold", pcpi_valid, 1);
      check("tmo_err_low", err_timeout, 0);
    end
    step();
    check("tmo_valid_drop", pcpi_valid, 0);
    check("tmo_err_set", err_timeout, 1);
    check("tmo_in_ready", in_ready, 1);
    check("tmo_out_valid", out_valid, 0);
    check("tmo_busy", busy, 0);

    // wait held for 100 cycles never times out; send_word checks the clear
    w  = $urandom();
    rd = $urandom();
    send_word(w);
    pcpi_wait = 1'b1;
    issue_ready(100, 1'b1, rd, w);
    pcpi_wait = 1'b0;
    recv_word(rd, 2);

    // ready in the same cycle as the timeout
    w  = $urandom();
    rd = $urandom();
    send_word(w);
    issue_ready(TIMEOUT - 1, 1'b1, rd, w);
    recv_word(rd, 0);

    // reset after five segments, then a fresh load
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 9);
      step();
    end
    in_valid = 1'b0;
    do_reset();
    w  = 32'h8765_4321;
    rd = $urandom();
    send_word(w);
    issue_ready(1, 1'b1, rd, w);
    recv_word(rd, 0);

    // reset mid-send, then a fresh transaction
    w = $urandom();
    send_word(w);
    issue_ready(0, 1'b1, 32'hA5A5_F0F1, w);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    do_reset();
    w  = $urandom();
    rd = $urandom();
    send_word(w);
    issue_ready(4, 1'b1, rd, w);
    recv_word(rd, 2);

    // randomized transactions: timeout after TIMEOUT consecutive non-wait cycles unless ready
    for (int t = 0; t < 24; t++) begin
      w         = $urandom();
      rd        = $urandom();
      wr        = ($urandom_range(0, 1) == 1);
      delay     = $urandom_range(0, 30);
      run       = 0;
      ended     = 1'b0;
      timed_out = 1'b0;
      send_word(w);
      for (int c = 0; c < 64 && !ended; c++) begin
        pcpi_wait  = ($urandom_range(0, 3) == 0);
        pcpi_ready = (c == delay);
        pcpi_wr    = wr;
        pcpi_rd    = rd;
        check("rnd_valid", pcpi_valid, 1);
        check("rnd_insn", pcpi_insn, w);
        run = pcpi_wait ? 0 : run + 1;
        step();
        if (c == delay) ended = 1'b1;
        else if (run == TIMEOUT) begin
          ended     = 1'b1;
          timed_out = 1'b1;
        end
      end
      pcpi_ready = 1'b0;
      pcpi_wr    = 1'b0;
      pcpi_wait  = 1'b0;
      check("rnd_valid_drop", pcpi_valid, 0);
      check("rnd_err", err_timeout, timed_out);
      check("rnd_out_valid", out_valid, !timed_out && wr);
      if (!timed_out && wr) recv_word(rd, 2);
      else check("rnd_in_ready", in_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
